// File: rtl/nanoz80_irq_pkg.sv
// rtl/nanoz80_irq_pkg.sv - shared constants and types for the nano-Z80 interrupt controller
package nanoz80_irq_pkg;

    localparam logic [2:0] IRQ_REG_CTRL     = 3'd0;
    localparam logic [2:0] IRQ_REG_PRESC_LO = 3'd1;
    localparam logic [2:0] IRQ_REG_PRESC_HI = 3'd2;
    localparam logic [2:0] IRQ_REG_COUNT    = 3'd3;
    localparam logic [2:0] IRQ_REG_PEND     = 3'd4;
    localparam logic [2:0] IRQ_REG_MASK     = 3'd5;
    localparam logic [2:0] IRQ_REG_VBASE    = 3'd6;
    localparam logic [2:0] IRQ_REG_CURR     = 3'd7;

    localparam int IRQ_SRC_TIMER = 0;
    localparam int IRQ_SRC_UART  = 1;
    localparam int IRQ_SRC_USB   = 2;
    localparam int IRQ_SRC_SD    = 3;
    localparam int IRQ_SRC_GPIO  = 4;

    localparam logic [2:0] IRQ_IDX_SPURIOUS = 3'd7;

    typedef enum logic [1:0] {
        ACK_IDLE    = 2'd0,
        ACK_BUSY    = 2'd1,
        ACK_RELEASE = 2'd2
    } ack_state_e;

endpackage

// File: rtl/irq_timer_core.sv
// rtl/irq_timer_core.sv - prescaler plus 8-bit down counter producing one expire pulse per period
module irq_timer_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ten_i,
    input  logic        auto_i,
    input  logic        load_i,
    input  logic [15:0] presc_i,
    input  logic [7:0]  count_i,
    output logic        expire_o,
    output logic [7:0]  curr_o
);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tick;

    assign tick     = ten_i & (presc_q == 16'd0);
    assign expire_o = tick & (cnt_q == 8'd0) & ~load_i;
    assign curr_o   = cnt_q;

    // Next prescaler/counter value: load wins, otherwise step only while running
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            presc_d = presc_i;
            cnt_d   = count_i;
        end else if (ten_i) begin
            if (presc_q == 16'd0) begin
                presc_d = presc_i;
                if (cnt_q == 8'd0) begin
                    if (auto_i) begin
                        cnt_d = count_i;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end else begin
                presc_d = presc_q - 16'd1;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= 16'd0;
            cnt_q   <= 8'd0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - nano-Z80 interrupt controller and interval timer; NANOZ80_IRQ_EXT_EN enables irq_i sources
import nanoz80_irq_pkg::*;

module irq_ctrl #(
    parameter int          NSRC      = 5,
    parameter logic [15:0] PRESC_RST = 16'hFFFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       irq_cs,
    input  logic [2:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic [3:0] irq_i,
    output logic [7:0] data_o,
    output logic       ack_o,
    output logic       int_n
);

    logic            wr_act, wr_act_q, wr_pulse;
    logic            wr_ctrl, wr_plo, wr_phi, wr_count, wr_pend, wr_mask, wr_vbase;
    logic            ten_q, auto_q, gie_q;
    logic [15:0]     presc_q;
    logic [7:0]      count_q;
    logic [3:0]      vbase_q;
    logic [NSRC-1:0] pend_q, pend_d, mask_q, pend_live, pend_set, ack_clr, ext_set;
    logic            int_n_q;
    ack_state_e      state_q, state_d;
    logic [2:0]      idx_q, prio_idx, vec_idx;
    logic            ack_req, ack_start;
    logic            timer_load, timer_run, timer_expire;
    logic [7:0]      timer_curr;

`ifdef NANOZ80_IRQ_EXT_EN
    localparam logic [NSRC-1:0] LIVE_BITS = '1;
    logic [3:0] irq_q;

    // Previous level of the request lines for rising-edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 4'd0;
        else       irq_q <= irq_i;
    end

    assign ext_set = {irq_i & ~irq_q, 1'b0};
`else
    localparam logic [NSRC-1:0] LIVE_BITS = NSRC'(1);
    logic unused_irq;

    assign unused_irq = ^irq_i;
    assign ext_set    = '0;
`endif

    // A held-low wr_n acts only on its first clock
    assign wr_act   = irq_cs & ~wr_n;
    assign wr_pulse = wr_act & ~wr_act_q;
    assign wr_ctrl  = wr_pulse & (reg_addr_i == IRQ_REG_CTRL);
    assign wr_plo   = wr_pulse & (reg_addr_i == IRQ_REG_PRESC_LO);
    assign wr_phi   = wr_pulse & (reg_addr_i == IRQ_REG_PRESC_HI);
    assign wr_count = wr_pulse & (reg_addr_i == IRQ_REG_COUNT);
    assign wr_pend  = wr_pulse & (reg_addr_i == IRQ_REG_PEND);
    assign wr_mask  = wr_pulse & (reg_addr_i == IRQ_REG_MASK);
    assign wr_vbase = wr_pulse & (reg_addr_i == IRQ_REG_VBASE);

    // Load on the TEN rising write; a TEN-clearing write already freezes this cycle
    assign timer_load = wr_ctrl & data_i[0] & ~ten_q;
    assign timer_run  = ten_q & ~(wr_ctrl & ~data_i[0]);

    irq_timer_core u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ten_i    (timer_run),
        .auto_i   (auto_q),
        .load_i   (timer_load),
        .presc_i  (presc_q),
        .count_i  (count_q),
        .expire_o (timer_expire),
        .curr_o   (timer_curr)
    );

    assign pend_live = pend_q & mask_q;
    assign ack_req   = ~m1_n & ~iorq_n & ~rst_i;
    assign ack_start = (state_q == ACK_IDLE) & ack_req;
    assign ack_clr   = ack_start ? (pend_live & (-pend_live)) : '0;
    assign pend_set  = ext_set | NSRC'(timer_expire);
    assign vec_idx   = (state_q == ACK_IDLE) ? prio_idx : idx_q;
    assign int_n     = int_n_q;

    // Lowest-numbered pending unmasked source wins; none gives the spurious index
    always_comb begin
        prio_idx = IRQ_IDX_SPURIOUS;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_live[i]) prio_idx = 3'(i);
        end
    end

    // Pending update: clears first, then new events so a same-cycle set survives
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) pend_d = pend_d & ~data_i[NSRC-1:0];
        pend_d = (pend_d & ~ack_clr) | pend_set;
        pend_d = pend_d & LIVE_BITS;
    end

    // Acknowledge sequencing and the combinational ack strobe
    always_comb begin
        state_d = state_q;
        ack_o   = 1'b0;
        case (state_q)
            ACK_IDLE: begin
                if (ack_req) begin
                    ack_o   = 1'b1;
                    state_d = ACK_BUSY;
                end
            end
            ACK_BUSY: begin
                ack_o = ~iorq_n;
                if (iorq_n) state_d = ACK_RELEASE;
            end
            ACK_RELEASE: state_d = ACK_IDLE;
            default:     state_d = ACK_IDLE;
        endcase
    end

    // Read mux, overridden by the vector byte during acknowledge
    always_comb begin
        data_o = 8'h00;
        if (ack_o) begin
            data_o = {vbase_q, vec_idx, 1'b0};
        end else begin
            case (reg_addr_i)
                IRQ_REG_CTRL:     data_o = {gie_q, 5'b00000, auto_q, ten_q};
                IRQ_REG_PRESC_LO: data_o = presc_q[7:0];
                IRQ_REG_PRESC_HI: data_o = presc_q[15:8];
                IRQ_REG_COUNT:    data_o = count_q;
                IRQ_REG_PEND:     data_o = 8'(pend_q);
                IRQ_REG_MASK:     data_o = 8'(mask_q);
                IRQ_REG_VBASE:    data_o = {vbase_q, 4'h0};
                IRQ_REG_CURR:     data_o = timer_curr;
                default:          data_o = 8'h00;
            endcase
        end
    end

    // Control register; a one-shot expiry stops the timer unless the CPU writes CTRL
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ten_q  <= 1'b0;
            auto_q <= 1'b0;
            gie_q  <= 1'b0;
        end else if (wr_ctrl) begin
            ten_q  <= data_i[0];
            auto_q <= data_i[1];
            gie_q  <= data_i[7];
        end else if (timer_expire && !auto_q) begin
            ten_q  <= 1'b0;
        end
    end

    // Configuration registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= PRESC_RST;
            count_q <= 8'd0;
            mask_q  <= '0;
            vbase_q <= 4'd0;
        end else begin
            if (wr_plo)   presc_q[7:0]  <= data_i;
            if (wr_phi)   presc_q[15:8] <= data_i;
            if (wr_count) count_q       <= data_i;
            if (wr_mask)  mask_q        <= data_i[NSRC-1:0] & LIVE_BITS;
            if (wr_vbase) vbase_q       <= data_i[7:4];
        end
    end

    // Pending, request, write-edge and acknowledge state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q   <= '0;
            int_n_q  <= 1'b1;
            wr_act_q <= 1'b0;
            state_q  <= ACK_IDLE;
            idx_q    <= IRQ_IDX_SPURIOUS;
        end else begin
            pend_q   <= pend_d;
            int_n_q  <= ~(gie_q & |pend_live);
            wr_act_q <= wr_act;
            state_q  <= state_d;
            if (ack_start) idx_q <= prio_idx;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;
    import nanoz80_irq_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i, wr_n, m1_n, iorq_n, irq_cs;
    logic [2:0] reg_addr_i;
    logic [7:0] data_i;
    logic [3:0] irq_i;
    logic [7:0] data_o;
    logic       ack_o, int_n;
    logic [7:0] rv;
    int         checks = 0;
    int         errors = 0;
    int         n;

`ifdef NANOZ80_IRQ_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    irq_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .iorq_n     (iorq_n),
        .irq_cs     (irq_cs),
        .reg_addr_i (reg_addr_i),
        .data_i     (data_i),
        .irq_i      (irq_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .int_n      (int_n)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        irq_cs = 1'b1; wr_n = 1'b0; reg_addr_i = a; data_i = d;
        tick();
        irq_cs = 1'b0; wr_n = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        reg_addr_i = a;
        #1;
        d = data_o;
    endtask

    task automatic do_ack(input logic [7:0] vec, input logic int_after);
        m1_n = 1'b0; iorq_n = 1'b0;
        #1;
        check("ack_rise", 8'(ack_o), 8'h01);
        check("ack_vector", data_o, vec);
        tick();
        check("ack_hold", 8'(ack_o), 8'h01);
        check("ack_vector_hold", data_o, vec);
        iorq_n = 1'b1; m1_n = 1'b1;
        #1;
        check("ack_fall", 8'(ack_o), 8'h00);
        tick();
        check("ack_int_after", 8'(int_n), 8'(int_after));
        tick();
    endtask

    // Periodic timer: expiries expected at multiples of (P+1)(C+1) after the load edge
    task automatic timer_trial(input int p, input int c, input int nexp);
        int t, next_set, last_set;
        t = (p + 1) * (c + 1);
        reg_wr(IRQ_REG_CTRL, 8'h80);
        reg_wr(IRQ_REG_PEND, 8'h1F);
        reg_wr(IRQ_REG_PRESC_LO, 8'(p));
        reg_wr(IRQ_REG_PRESC_HI, 8'h00);
        reg_wr(IRQ_REG_COUNT, 8'(c));
        reg_wr(IRQ_REG_CTRL, 8'h83);
        reg_addr_i = IRQ_REG_PEND;
        data_i     = 8'h01;
        #1;
        next_set = t;
        last_set = -10;
        for (int k = 1; k <= nexp * t + 1; k++) begin
            if (k > 1) begin
                tick();
                irq_cs = 1'b0; wr_n = 1'b1;
            end
            check("tmr_pend", data_o, 8'(k == next_set));
            check("tmr_int_n", 8'(int_n), 8'(k != last_set + 1));
            if (k == next_set) begin
                last_set = k;
                next_set = next_set + t;
                irq_cs = 1'b1; wr_n = 1'b0;
            end
        end
        tick();
        reg_wr(IRQ_REG_CTRL, 8'h80);
    endtask

    initial begin
        rst_i = 1'b1; wr_n = 1'b1; m1_n = 1'b1; iorq_n = 1'b1; irq_cs = 1'b0;
        reg_addr_i = 3'd0; data_i = 8'h00; irq_i = 4'h0;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();

        check("rst_int_n", 8'(int_n), 8'h01);
        check("rst_ack_o", 8'(ack_o), 8'h00);
        check("rst_data_o", data_o, 8'h00);
        rd(IRQ_REG_PRESC_LO, rv); check("rst_presc_lo", rv, 8'hFF);
        rd(IRQ_REG_PRESC_HI, rv); check("rst_presc_hi", rv, 8'hFF);
        rd(IRQ_REG_PEND, rv);     check("rst_pend", rv, 8'h00);
        rd(IRQ_REG_MASK, rv);     check("rst_mask", rv, 8'h00);

        reg_wr(IRQ_REG_MASK, 8'h1F);
        rd(IRQ_REG_MASK, rv); check("mask_live", rv, EXT ? 8'h1F : 8'h01);
        reg_wr(IRQ_REG_VBASE, 8'h40);

        timer_trial(3, 2, 3);
        for (int r = 0; r < 3; r++) begin
            timer_trial(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 2);
        end

        // One-shot expiry then acknowledge of the timer source
        reg_wr(IRQ_REG_PEND, 8'h1F);
        reg_wr(IRQ_REG_PRESC_LO, 8'd3);
        reg_wr(IRQ_REG_PRESC_HI, 8'd0);
        reg_wr(IRQ_REG_COUNT, 8'd2);
        reg_wr(IRQ_REG_CTRL, 8'h81);
        reg_addr_i = IRQ_REG_PEND;
        #1;
        n = 1;
        while (n < 40 && data_o[0] !== 1'b1) begin
            tick();
            n++;
        end
        check("oneshot_latency", 8'(n), 8'd12);
        tick();
        check("oneshot_int_low", 8'(int_n), 8'h00);
        rd(IRQ_REG_CTRL, rv); check("oneshot_ten_clr", rv, 8'h80);
        do_ack(8'h40, 1'b1);
        rd(IRQ_REG_PEND, rv); check("ack_pend_clr", rv, 8'h00);

        // Timer plus USB pending; P=0,C=0 one-shot fires one clock after load
        reg_wr(IRQ_REG_PRESC_LO, 8'd0);
        reg_wr(IRQ_REG_COUNT, 8'd0);
        irq_i = 4'b0010;
        reg_wr(IRQ_REG_CTRL, 8'h81);
        rd(IRQ_REG_CTRL, rv); check("p0c0_ten_clr", rv, 8'h80);
        rd(IRQ_REG_PEND, rv); check("two_pend", rv, EXT ? 8'h05 : 8'h01);
        tick();
        check("two_int_low", 8'(int_n), 8'h00);
        do_ack(8'h40, !EXT);
        do_ack(EXT ? 8'h44 : 8'h4E, 1'b1);
        repeat (20) tick();
        rd(IRQ_REG_PEND, rv); check("p0c0_no_refire", rv, 8'h00);
        check("two_int_high", 8'(int_n), 8'h01);
        irq_i = 4'h0;

        // Held write strobe: clears once, same-cycle expiry wins
        reg_wr(IRQ_REG_PRESC_LO, 8'd1);
        reg_wr(IRQ_REG_COUNT, 8'd1);
        reg_wr(IRQ_REG_PEND, 8'h1F);
        reg_wr(IRQ_REG_CTRL, 8'h83);
        tick();
        tick();
        rd(IRQ_REG_PEND, rv); check("hold_pre", rv, 8'h00);
        irq_cs = 1'b1; wr_n = 1'b0; data_i = 8'h01;
        tick();
        check("hold_set_wins", data_o, 8'h01);
        repeat (3) tick();
        check("hold_once", data_o, 8'h01);
        irq_cs = 1'b0; wr_n = 1'b1;
        tick();
        reg_wr(IRQ_REG_CTRL, 8'h80);
        reg_wr(IRQ_REG_PEND, 8'h1F);

        // Clearing TEN freezes the counter on the write clock
        reg_wr(IRQ_REG_PRESC_LO, 8'd0);
        reg_wr(IRQ_REG_COUNT, 8'd5);
        reg_wr(IRQ_REG_CTRL, 8'h83);
        irq_cs = 1'b1; wr_n = 1'b0; reg_addr_i = IRQ_REG_CTRL; data_i = 8'h82;
        tick();
        irq_cs = 1'b0; wr_n = 1'b1;
        rd(IRQ_REG_CURR, rv); check("freeze_curr", rv, 8'd4);
        repeat (3) tick();
        rd(IRQ_REG_CURR, rv); check("freeze_curr_hold", rv, 8'd4);
        rd(IRQ_REG_CTRL, rv); check("freeze_ctrl", rv, 8'h82);
        reg_wr(IRQ_REG_CTRL, 8'h80);

        // External edge to int_n latency
        reg_wr(IRQ_REG_PEND, 8'h1F);
        irq_i = 4'b1000;
        tick();
        check("ext_lat_1", 8'(int_n), 8'h01);
        tick();
        check("ext_lat_2", 8'(int_n), EXT ? 8'h00 : 8'h01);
        rd(IRQ_REG_PEND, rv); check("ext_pend", rv, EXT ? 8'h10 : 8'h00);
        irq_i = 4'h0;
        reg_wr(IRQ_REG_PEND, 8'h1F);
        check("ext_clr_int", 8'(int_n), 8'h01);

        // Reset during an acknowledge with the timer firing every clock
        reg_wr(IRQ_REG_COUNT, 8'd0);
        reg_wr(IRQ_REG_CTRL, 8'h83);
        tick();
        check("rst_pre_int", 8'(int_n), 8'h00);
        m1_n = 1'b0; iorq_n = 1'b0;
        #1;
        check("rst_pre_ack", 8'(ack_o), 8'h01);
        check("rst_pre_vec", data_o, 8'h40);
        tick();
        rst_i = 1'b1;
        #1;
        check("rst_mid_int", 8'(int_n), 8'h01);
        check("rst_mid_ack", 8'(ack_o), 8'h00);
        rd(IRQ_REG_PEND, rv); check("rst_mid_pend", rv, 8'h00);
        rd(IRQ_REG_CTRL, rv); check("rst_mid_ctrl", rv, 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick();
        rst_i = 1'b0;
        repeat (4) tick();
        rd(IRQ_REG_PEND, rv); check("rst_post_pend", rv, 8'h00);
        check("rst_post_int", 8'(int_n), 8'h01);
        check("rst_post_ack", 8'(ack_o), 8'h00);
        rd(IRQ_REG_PRESC_HI, rv); check("rst_post_presc", rv, 8'hFF);
        do_ack(8'h0E, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller with integrated programmable interval timer for the nano-Z80. It sits on the CPU I/O bus beside the other peripherals and drives the CPU `int_n` input, which is currently tied high. During a mode-2 interrupt acknowledge it supplies the vector byte through the top-level CPU data-in mux. Pending sources are the timer and, optionally, four peripheral request lines (UART RX, USB, SD, GPIO).

## Interface
- `NSRC`, 5: number of interrupt sources; bit 0 is the timer, bits 4:1 are `irq_i[3:0]`.
- `PRESC_RST`, 16'hFFFF: prescaler reload value after reset.
- `clk_i`  in  1  system clock, same clock as the CPU.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wr_n`  in  1  CPU write strobe, active low.
- `m1_n`  in  1  CPU M1, active low.
- `iorq_n`  in  1  CPU IORQ, active low.
- `irq_cs`  in  1  register select from `addr_decoder`; asserted only for I/O cycles.
- `reg_addr_i`  in  3  register index (`cpu_addr[2:0]`).
- `data_i`  in  8  CPU write data.
- `irq_i`  in  4  peripheral request lines, synchronous to `clk_i`, level-high.
- `data_o`  out  8  register read data, or the vector byte while `ack_o` is high.
- `ack_o`  out  1  high while an acknowledge cycle is in progress; the top-level mux gives it highest priority.
- `int_n`  out  1  interrupt request to the CPU, active low, registered.

## Operation
- Registers:
  - 0 CTRL: bit0 TEN (timer run), bit1 AUTO (reload), bit7 GIE (global enable).
  - 1 PRESC_LO and 2 PRESC_HI: 16-bit prescaler reload P.
  - 3 COUNT: 8-bit count reload C.
  - 4 PEND: read returns pending bits; write 1 clears the bit.
  - 5 MASK: 1 enables the source.
  - 6 VBASE: bits 7:4 of the vector.
  - 7 CURR: read-only, current count value.
- Register reset values are 0, except PRESC, which resets to `PRESC_RST`.
- Write strobe:
  - A write executes once, on the first clock where `irq_cs & ~wr_n` is high after being low.
  - The Z80 holds `wr_n` low for multiple clocks; those extra clocks have no further effect.
- Reads have no side effects.
- Timer:
  - When TEN rises, the prescaler loads P and the counter loads C.
  - The prescaler decrements every clock. At 0 it reloads P and issues a tick, so a tick occurs every P+1 clocks.
  - Each tick decrements the counter. A tick at counter 0 sets PEND[0].
  - At that point the counter reloads C if AUTO=1. If AUTO=0, TEN clears in the same cycle.
  - Expiry period is (P+1)·(C+1) clocks.
- External sources: a rising edge on `irq_i[n]` (registered compare) sets PEND[n+1].
- Request: the `int_n` register is loaded with ~(GIE & |(PEND & MASK)).
- Acknowledge:
  - An acknowledge cycle is `~m1_n & ~iorq_n`. Its first cycle latches the highest-priority pending, unmasked source; the lowest index has the highest priority.
  - During the cycle: `ack_o`=1, `data_o` = {VBASE[7:4], idx[2:0], 1'b0}.
  - The latched bit in PEND clears at the first acknowledge cycle.
  - If nothing is pending (spurious acknowledge), idx=7.
- State machine has three states:
  - IDLE → ACK on acknowledge start.
  - ACK → RELEASE when `iorq_n` rises.
  - RELEASE → IDLE after one clock.
- Simultaneous events:
  - A set from the timer or an edge beats a same-cycle PEND write-clear or acknowledge-clear.
  - A write to COUNT while running takes effect at the next reload only.
  - Clearing TEN freezes the prescaler and counter immediately.
- Reset mid-operation forces IDLE: `int_n`=1, `ack_o`=0, PEND=0, and counters stop.

## Timing
- Reset values of outputs: `int_n`=1, `ack_o`=0, `data_o`=0 (CTRL).
- `data_o` is combinational from `reg_addr_i` and register state, with zero-cycle read latency.
- Latency from a PEND bit setting to `int_n` low is 1 clock.
- Latency from a source edge on `irq_i` to `int_n` low is 2 clocks.
- `ack_o` rises in the same cycle the acknowledge is detected (combinational on `m1_n`/`iorq_n` in IDLE) and stays high until `iorq_n` rises.
- After PEND clears on acknowledge, `int_n` deasserts 1 clock later if nothing else is pending.

## Configuration
- `NANOZ80_IRQ_EXT_EN` defined:
  - `irq_i` edge detection is compiled in.
  - PEND/MASK bits 4:1 are live.
- `NANOZ80_IRQ_EXT_EN` undefined:
  - `irq_i` is ignored.
  - PEND/MASK bits 4:1 read 0 and ignore writes.
  - Only the timer can interrupt.

## Structure
- Shared package `nanoz80_irq_pkg` holds:
  - register index constants (`IRQ_REG_CTRL` … `IRQ_REG_CURR`);
  - source indices (`IRQ_SRC_TIMER`=0, `IRQ_SRC_UART`=1, `IRQ_SRC_USB`=2, `IRQ_SRC_SD`=3, `IRQ_SRC_GPIO`=4);
  - spurious index 7;
  - the acknowledge state enum.
- Sub-module `irq_timer_core` contains the prescaler and counter. Its interface is TEN, AUTO, P, C, load pulse in, and expire pulse out.

## Test plan
- P=3, C=2, AUTO=1, MASK=1, GIE=1, TEN=1 → PEND[0] sets every 12 clocks and `int_n` falls 1 clock later.
- Acknowledge with VBASE=0x40 and timer pending → `ack_o`=1, `data_o`=0x40, PEND[0] cleared, `int_n`=1 one clock after.
- PEND bits 0 and 2 (USB) pending → the first acknowledge returns 0x40, the second returns 0x44, then `int_n` stays high.
- `wr_n` held low for 4 clocks writing 0x01 to PEND → PEND[0] clears once, and a same-cycle timer expiry leaves PEND[0]=1.
- AUTO=0, P=0, C=0 → a single expiry after 1 clock, after which TEN reads 0 and there is no further PEND set.
- `rst_i` asserted during ACK → `int_n`=1, `ack_o`=0, PEND=0 asynchronously, and the block is in IDLE after release.
